// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: IDLE -> ACCESS -> DONE per transaction, registered memory drive.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, nextState;
  logic   grantSel;  // 0 = port 0, 1 = port 1; meaningful only while a request is present
  logic   winner;
  logic   anyReq;

  assign anyReq = req0 | req1;
  assign busy   = (state != IDLE);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic prio1;  // 1 = port 1 wins the next tie

  always_comb begin
    grantSel = req1;
    if (req0 && req1) grantSel = prio1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prio1 <= 1'b0;
    else if (state == IDLE && anyReq) prio1 <= ~grantSel;
  end
`else
  always_comb grantSel = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ACCESS;
      ACCESS:  nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Strobes and acks are registered so they are clean for a full cycle;
  // mem_addr/mem_wdata only change on a grant, so they never follow the other port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      winner    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            winner    <= grantSel;
            mem_addr  <= grantSel ? addr1  : addr0;
            mem_wdata <= grantSel ? wdata1 : wdata0;
            mem_write <= grantSel ? we1    : we0;
            mem_read  <= grantSel ? ~we1   : ~we0;
          end
        end
        ACCESS: begin
          if (mem_read) rdata <= mem_rdata;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          ack0      <= ~winner;
          ack1      <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural data memory.
// Expectations for the contention scenario follow DMEM_ARB_ROUND_ROBIN_EN when defined.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [10:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic        monOn = 1'b0;
  logic        preloadEn;
  logic [10:0] preAddr;
  logic [31:0] preData;
  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory commits a write only on an edge where reset is not asserted.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (preloadEn) mem[preAddr] <= preData;
    else if (mem_write && rst_n) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (monOn) begin
      checks++;
      assert (!(mem_read && mem_write)) else begin
        errors++; $error("FAIL mutex_rw observed=%b%b expected=not both", mem_read, mem_write);
      end
      checks++;
      assert (!(ack0 && ack1)) else begin
        errors++; $error("FAIL mutex_ack observed=%b%b expected=not both", ack0, ack1);
      end
      checks++;
      assert (busy === (mem_read | mem_write | ack0 | ack1)) else begin
        errors++; $error("FAIL busy_state observed=%b expected=%b", busy, mem_read | mem_write | ack0 | ack1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one uncontended transaction starting in IDLE and ends back in IDLE.
  task automatic txn(input logic port, input logic we, input logic [10:0] a,
                     input logic [31:0] wd, input logic [31:0] expRd);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    tick();
    chk("acc_busy", {31'd0, busy}, 32'd1);
    chk("acc_read", {31'd0, mem_read}, {31'd0, ~we});
    chk("acc_write", {31'd0, mem_write}, {31'd0, we});
    chk("acc_addr", {21'd0, mem_addr}, {21'd0, a});
    if (we) chk("acc_wdata", mem_wdata, wd);
    chk("acc_noack", {30'd0, ack0, ack1}, 32'd0);
    tick();
    chk("done_ack", {30'd0, ack0, ack1}, port ? 32'd1 : 32'd2);
    chk("done_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("done_rdata", rdata, expRd);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_noack", {30'd0, ack0, ack1}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 11'h7FF; addr1 = 11'h005; wdata0 = '0; wdata1 = '0;
    preloadEn = 1'b1; preAddr = 11'h7FF; preData = 32'hCAFEF00D;
    tick();
    preAddr = 11'h010; preData = 32'h12345678;
    tick();
    preAddr = 11'h005; preData = 32'h0;
    tick();
    preloadEn = 1'b0;
    monOn = 1'b1;

    // Reset held with both requests high: everything quiet
    chk("rst_ack", {30'd0, ack0, ack1}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_addr", {21'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // First grant after release goes to port 0, then the pending port 1
    rst_n = 1'b1;
    tick();
    chk("p0first_read", {31'd0, mem_read}, 32'd1);
    chk("p0first_addr", {21'd0, mem_addr}, 32'h7FF);
    tick();
    chk("p0first_ack", {30'd0, ack0, ack1}, 32'd2);
    chk("p0first_rdata", rdata, 32'hCAFEF00D);
    req0 = 1'b0;
    tick();
    chk("gap_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("p1next_addr", {21'd0, mem_addr}, 32'h005);
    chk("p1next_noack", {30'd0, ack0, ack1}, 32'd0);
    tick();
    chk("p1next_ack", {30'd0, ack0, ack1}, 32'd1);
    chk("p1next_rdata", rdata, 32'd0);
    req1 = 1'b0;
    tick();

    // Port 1 write, port 0 reads it back; rdata holds across the write
    txn(1'b1, 1'b1, 11'h005, 32'hDEADBEEF, 32'd0);
    txn(1'b0, 1'b0, 11'h005, 32'd0, 32'hDEADBEEF);
    txn(1'b0, 1'b0, 11'h7FF, 32'd0, 32'hCAFEF00D);

    // Continuous contention, both reading; last grant before this was port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h7FF;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h005;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk("cont_acc_noack", {30'd0, ack0, ack1}, 32'd0);
      tick();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      chk("cont_ack", {30'd0, ack0, ack1}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_rdata", rdata, (i % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
`else
      chk("cont_ack", {30'd0, ack0, ack1}, 32'd2);
      chk("cont_rdata", rdata, 32'hCAFEF00D);
`endif
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      chk("cont_idle_noack", {30'd0, ack0, ack1}, 32'd0);
    end

    // Reset during the ACCESS cycle of a write to 0x010
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h010; wdata0 = 32'hBAD0BAD0;
    tick();
    chk("abort_acc_write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_noack", {30'd0, ack0, ack1}, 32'd0);
    chk("abort_nowrite", {31'd0, mem_write}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_mem", mem[11'h010], 32'h12345678);
    req0 = 1'b0; we0 = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("abort_idle_noack", {30'd0, ack0, ack1}, 32'd0);
    txn(1'b1, 1'b0, 11'h010, 32'd0, 32'h12345678);

    monOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, word-address width matching the data memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0 / req1  input  1 each  access request from port 0 (CPU load/store) and port 1 (DMA/IO); held high until ack.
REQ-006 we0 / we1  input  1 each  1 = write, 0 = read; stable while req high.
REQ-007 addr0 / addr1  input  ADDR_W each  word address; stable while req high.
REQ-008 wdata0 / wdata1  input  DATA_W each  write data; stable while req high.
REQ-009 ack0 / ack1  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  DATA_W  read data, valid in the ack cycle of a read.
REQ-011 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_write  output  1, mem_read  output  1  registered drive to the data memory.
REQ-012 mem_rdata  input  DATA_W  combinational read data from the memory.
REQ-013 busy  output  1  high in ACCESS and DONE.

Function
REQ-014 FSM states IDLE, ACCESS, DONE; encoding free.
REQ-015 IDLE: no req -> stay; any req -> ACCESS, latching winner index, we, addr and wdata into the mem_* registers.
REQ-016 ACCESS lasts exactly one cycle: mem_read = !we and mem_write = we of the winner; the other strobe is 0; at the end of the cycle rdata is loaded from mem_rdata (reads only, otherwise held); -> DONE.
REQ-017 DONE lasts exactly one cycle: ackN = 1 for the winner only; mem_read = mem_write = 0; -> IDLE; requests are not sampled in DONE.
REQ-018 Latency: req sampled high at edge t -> ack high during cycle t+2; minimum 3 cycles per transaction per port.
REQ-019 The requester drops or updates req/addr/wdata at the edge closing the ack cycle; a req still high in the following IDLE cycle is a new transaction.
REQ-020 Simultaneous req0 and req1 in IDLE: winner chosen per REQ-027/REQ-028; the loser stays pending and is served next with no idle gap beyond the mandatory IDLE cycle.
REQ-021 At most one of mem_read, mem_write is high in any cycle; never both ack0 and ack1.
REQ-022 mem_addr and mem_wdata hold their last value outside ACCESS; they do not glitch to the other port.
REQ-023 rdata holds its last loaded value until the next read's ACCESS completes.
REQ-024 A req dropped before its ack is a protocol violation; the transaction still completes and acks.

Reset
REQ-025 While rst_n = 0 at a rising edge: state = IDLE, ack0 = ack1 = 0, mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, busy = 0, round-robin pointer = port 0 priority.
REQ-026 Reset asserted mid-ACCESS or mid-DONE aborts the transaction: no ack is issued and no write occurs after the reset edge.

Configuration
REQ-027 Macro DMEM_ARB_ROUND_ROBIN_EN defined: round-robin; the port granted last has lowest priority on the next tie; the pointer updates only on a grant.
REQ-028 Macro not defined: fixed priority; port 0 always wins ties; the pointer logic is absent.

Verification
REQ-029 Reset with both reqs high -> all outputs 0 during reset; first IDLE after release grants port 0.
REQ-030 Port 1 write addr 0x005, data 0xDEADBEEF; then port 0 read 0x005 -> mem_write high exactly one cycle; ack1 at t+2; ack0 with rdata = 0xDEADBEEF.
REQ-031 req0 and req1 held continuously, each read, with DMEM_ARB_ROUND_ROBIN_EN -> acks alternate 0,1,0,1 every 3 cycles; without the macro -> port 1 starved while req0 is held.
REQ-032 Read addr 0x7FF (top word) -> mem_addr = 0x7FF; rdata equals preloaded memory word.
REQ-033 rst_n pulled low during the ACCESS cycle of a write to 0x010 -> no ack, memory word 0x010 unchanged if the write edge fell under reset, and FSM in IDLE afterwards.
REQ-034 Throughout all scenarios, assertions: never mem_read & mem_write, never ack0 & ack1, busy matches state.
